// File: rtl/regfile_multiport_if.sv
// Register-file access bundle: NRD read ports, ALU/load write ports, reservation request and busy flag.
// The datapath drives through the master modport and the register file sits on the slave modport.
interface regfile_multiport_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_pend;
  logic                we0;
  logic [AW-1:0]       wa0;
  logic [XLEN-1:0]     wd0;
  logic                we1;
  logic [AW-1:0]       wa1;
  logic [XLEN-1:0]     wd1;
  logic                rsv;
  logic [AW-1:0]       rsv_addr;
  logic                busy_any;

  modport master (
    output rd_addr, we0, wa0, wd0, we1, wa1, wd1, rsv, rsv_addr,
    input  rd_data, rd_pend, busy_any
  );

  modport slave (
    input  rd_addr, we0, wa0, wd0, we1, wa1, wd1, rsv, rsv_addr,
    output rd_data, rd_pend, busy_any
  );
endinterface

// File: rtl/regfile_multiport.sv
// Multiport integer register file with pending scoreboard; zero-latency reads, writes on clk, no backpressure.
// Define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data (and we1 pend clears) to the read ports.
module regfile_multiport #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
) (
  input logic          clk,
  input logic          reset,
  regfile_multiport_if.slave bus
);
  localparam int AW = $clog2(NREG);

  if (NREG < 2 || (NREG & (NREG - 1)) != 0) begin : g_bad_nreg
    $error("regfile_multiport: NREG must be a power of two and at least 2");
  end
  if (NRD < 1 || NRD > 4) begin : g_bad_nrd
    $error("regfile_multiport: NRD must be in 1..4");
  end

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nxt;

  // A reservation issued in the same cycle as an older load completing must survive.
  always_comb begin
    pend_nxt = pend;
    for (int r = 1; r < NREG; r++) begin
      if (bus.we1 && bus.wa1 == AW'(r)) pend_nxt[r] = 1'b0;
      if (bus.rsv && bus.rsv_addr == AW'(r)) pend_nxt[r] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
      pend <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (bus.we1 && bus.wa1 == AW'(r))      regs[r] <= bus.wd1;
        else if (bus.we0 && bus.wa0 == AW'(r)) regs[r] <= bus.wd0;
      end
      pend <= pend_nxt;
    end
  end

  logic [AW-1:0]   ra;
  logic [XLEN-1:0] rdv;
  logic            rpv;

  always_comb begin
    bus.rd_data = '0;
    bus.rd_pend = '0;
    ra  = '0;
    rdv = '0;
    rpv = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      ra  = bus.rd_addr[i*AW +: AW];
      rdv = (ra == '0) ? '0 : regs[ra];
      rpv = pend[ra];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (ra != '0) begin
        if (bus.we0 && bus.wa0 == ra) rdv = bus.wd0;
        if (bus.we1 && bus.wa1 == ra) begin
          rdv = bus.wd1;
          rpv = 1'b0;
        end
      end
`endif
      bus.rd_data[i*XLEN +: XLEN] = rdv;
      bus.rd_pend[i]              = rpv;
    end
  end

  assign bus.busy_any = |pend;
endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised integer register file for the multicycle RISC-V datapath; generalises the single-write, two-read file.
- Provides NRD combinational read ports and two write ports (ALU writeback, load writeback).
- Keeps a per-register pending scoreboard so control can stall on a register whose load result has not yet returned.
- Register 0 is hardwired to zero.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of registers; power of two, at least 2.
- NRD, 2, number of read ports, 1 to 4.
- AW, $clog2(NREG), address width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  NRD*AW  read addresses; port i at bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data; port i at bits [i*XLEN +: XLEN].
- rd_pend  out  NRD  pending bit of the register addressed by each read port.
- we0  in  1  write enable, port 0 (ALU writeback).
- wa0  in  AW  write address, port 0.
- wd0  in  XLEN  write data, port 0.
- we1  in  1  write enable, port 1 (load writeback).
- wa1  in  AW  write address, port 1.
- wd1  in  XLEN  write data, port 1.
- rsv  in  1  reserve request; marks register rsv_addr pending.
- rsv_addr  in  AW  register to reserve.
- busy_any  out  1  OR of all pending bits.

Behaviour:
- Reset: asynchronous, active-high. While reset is asserted, all NREG registers are 0 and all pending bits are 0; rd_data reads 0, rd_pend reads 0, busy_any is 0. Deassertion takes effect at the next clk edge.
- Read: combinational, zero latency. rd_data[i] = regs[rd_addr[i]]; address 0 always returns 0.
- Write: on the rising clk edge, if weN is high and waN != 0, regs[waN] <= wdN. Writes to address 0 are discarded.
- Write collision: we0 and we1 both high with wa0 == wa1 != 0 -> the port 1 value is written and the port 0 value is dropped.
- Scoreboard, each edge, per register r != 0:
  - set if rsv is high and rsv_addr == r;
  - clear if we1 is high and wa1 == r;
  - set and clear in the same cycle -> the set wins; a new reservation follows an old completion.
  - we0 never clears a pending bit.
- pend[0] is constant 0; rsv with rsv_addr == 0 is ignored.
- rd_pend[i] = pend[rd_addr[i]], registered state only, without the same-cycle update. busy_any = OR of pend.
- Reset asserted mid-operation: all contents and pending bits are lost immediately; an in-flight reservation is abandoned.
- NREG is not a power of two, or NRD is outside 1..4: elaboration error.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: a read whose address matches an active same-cycle write (address != 0) returns that write's data combinationally instead of the stored value. If both write ports match, port 1 data is returned. rd_pend for that port also reflects a same-cycle clear by we1.
- Undefined: reads return stored state only; new data is visible the cycle after the write edge.

Test Plan:
- Reset: assert reset mid-run after writing 0xDEADBEEF to x5 -> rd_data for x5 = 0 immediately (asynchronous, no clk edge needed); busy_any = 0.
- x0 protection: we0=1, wa0=0, wd0=0xFFFFFFFF, then read x0 -> rd_data = 0.
- Collision: we0=we1=1, wa0=wa1=7, wd0=0x11, wd1=0x22 -> x7 = 0x22 on the next cycle.
- Scoreboard:
  - rsv=1, rsv_addr=9 -> rd_pend=1 and busy_any=1 next cycle;
  - we0 to x9 -> still pending;
  - we1 to x9 -> rd_pend=0 and busy_any=0 next cycle;
  - rsv and we1 on x9 in the same cycle -> pend stays 1.
- Multi-port read: NRD=4, read x1..x4 preloaded with 1..4 in one cycle -> rd_data = {4,3,2,1} packed.
- Bypass: we1=1, wa1=3, wd1=0xABCD with rd_addr=3 in the same cycle -> 0xABCD with REGFILE_WRITE_BYPASS_EN defined, old value without it.
